// File: rtl/spi_slave_tx.sv
// SPI mode-0 transmit-only slave: loads a WIDTH-bit frame on the clk side and shifts it out MSB first on miso.
// Define SPI_SLAVE_TX_DBG_EN to expose the state (_dbg_cs) and bit counter (_dbg_idx) as extra outputs.
module spi_slave_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    input  logic             sck,
    input  logic             ss,
    output logic             miso,
    output logic             busy,
    output logic             armed,
    output logic             done,
    output logic             err
`ifdef SPI_SLAVE_TX_DBG_EN
    ,
    output logic [1:0]       _dbg_cs,
    output logic [3:0]       _dbg_idx
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        SHIFT   = 2'd2,
        WAIT_SS = 2'd3
    } state_t;

    // Counter must reach WIDTH itself, so 5 bits covers the full 2..16 range.
    localparam logic [4:0] LAST_BIT = 5'(WIDTH - 1);

    state_t           state, state_next;
    logic [WIDTH-1:0] shreg, shreg_next;
    logic [4:0]       bit_cnt, bit_cnt_next;
    logic             done_next, err_next, miso_next;

    logic sck_meta, sck_sync, sck_prev;
    logic ss_meta, ss_sync, ss_prev;
    logic sck_rise, sck_fall, ss_rise, ss_fall;

    assign sck_rise = sck_sync & ~sck_prev;
    assign sck_fall = ~sck_sync & sck_prev;
    assign ss_rise  = ss_sync & ~ss_prev;
    assign ss_fall  = ~ss_sync & ss_prev;

    // NOTE: every signal written here gets a default first so no path leaves one unassigned (which would infer a latch).
    always_comb begin
        state_next   = state;
        shreg_next   = shreg;
        bit_cnt_next = bit_cnt;
        done_next    = 1'b0;
        err_next     = 1'b0;
        unique case (state)
            IDLE: begin
                if (load) begin
                    shreg_next = data_in;
                end
                // An ss edge with nothing armed is an underrun even if a load lands on the same cycle.
                if (ss_fall) begin
                    state_next = WAIT_SS;
                    err_next   = 1'b1;
                end else if (load) begin
                    state_next = ARMED;
                end
            end
            ARMED: begin
                if (load) begin
                    shreg_next = data_in;
                end
                if (ss_fall) begin
                    state_next   = SHIFT;
                    bit_cnt_next = '0;
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    state_next = IDLE;
                    shreg_next = '0;
                    err_next   = 1'b1;
                end else if (sck_rise) begin
                    bit_cnt_next = bit_cnt + 5'd1;
                    if (bit_cnt == LAST_BIT) begin
                        state_next = WAIT_SS;
                        done_next  = 1'b1;
                    end
                end else if (sck_fall) begin
                    shreg_next = {shreg[WIDTH-2:0], 1'b0};
                end
            end
            WAIT_SS: begin
                if (ss_rise) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // miso is registered from the next-state view so the MSB is already on the wire while ARMED.
    assign miso_next = ((state_next == ARMED) || (state_next == SHIFT)) ? shreg_next[WIDTH-1] : 1'b0;

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_meta <= 1'b0;
            sck_sync <= 1'b0;
            sck_prev <= 1'b0;
            ss_meta  <= 1'b1;
            ss_sync  <= 1'b1;
            ss_prev  <= 1'b1;
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            miso     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            sck_meta <= sck;
            sck_sync <= sck_meta;
            sck_prev <= sck_sync;
            ss_meta  <= ss;
            ss_sync  <= ss_meta;
            ss_prev  <= ss_sync;
            state    <= state_next;
            shreg    <= shreg_next;
            bit_cnt  <= bit_cnt_next;
            miso     <= miso_next;
            done     <= done_next;
            err      <= err_next;
        end
    end

    assign busy  = (state == SHIFT) || (state == WAIT_SS);
    assign armed = (state == ARMED);

`ifdef SPI_SLAVE_TX_DBG_EN
    assign _dbg_cs  = state;
    assign _dbg_idx = bit_cnt[3:0];
`endif

endmodule

// File: tb/tb_spi_slave_tx.sv
// Self-checking bench for spi_slave_tx: directed vector table, hand-written corner sequences, and a
// randomized frame stream checked against a frame-level reference model.
module tb_spi_slave_tx;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] data_in = '0;
    logic             load = 1'b0;
    logic             sck = 1'b0;
    logic             ss = 1'b1;
    logic             miso, busy, armed, done, err;
`ifdef SPI_SLAVE_TX_DBG_EN
    logic [1:0]       dbg_cs;
    logic [3:0]       dbg_idx;
`endif

    always #5 clk = ~clk;

    spi_slave_tx #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_in),
        .load    (load),
        .sck     (sck),
        .ss      (ss),
        .miso    (miso),
        .busy    (busy),
        .armed   (armed),
        .done    (done),
        .err     (err)
`ifdef SPI_SLAVE_TX_DBG_EN
        ,
        ._dbg_cs (dbg_cs),
        ._dbg_idx(dbg_idx)
`endif
    );

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;

    // Pulse counters sampled on the falling clk edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (done && err) both_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [7:0] d);
        data_in = d;
        load    = 1'b1;
        tick(1);
        load    = 1'b0;
    endtask

    // Master side of one mode-0 frame at clk/8; optionally pulses load during the shift.
    task automatic spi_frame(input int nbits, input logic mid_load, input logic [7:0] mid_data,
                             output logic [7:0] rx, output logic busy_end);
        rx = '0;
        ss = 1'b0;
        tick(4);
        for (int i = 0; i < nbits; i++) begin
            rx  = {rx[6:0], miso};
            sck = 1'b1;
            if (mid_load && i == 2) begin
                do_load(mid_data);
                tick(3);
            end else begin
                tick(4);
            end
            sck = 1'b0;
            tick(4);
        end
        busy_end = busy;
        ss = 1'b1;
        tick(6);
    endtask

    typedef struct {
        logic       do_load;
        logic [7:0] data;
        logic [7:0] exp_rx;
        int         exp_done;
        int         exp_err;
    } vec_t;

    vec_t       vecs[5];
    logic [7:0] rx, d, md, model_data, exp_rx;
    logic       busy_end, model_armed, mid;
    int         d0, e0, n_loads;

    initial begin
        vecs[0] = '{1'b1, 8'hA5, 8'hA5, 1, 0};
        vecs[1] = '{1'b1, 8'h55, 8'h55, 1, 0};
        vecs[2] = '{1'b1, 8'hFF, 8'hFF, 1, 0};
        vecs[3] = '{1'b1, 8'h01, 8'h01, 1, 0};
        vecs[4] = '{1'b0, 8'h9A, 8'h00, 0, 1};

        tick(3);
        check("reset_miso", miso, 0);
        check("reset_busy", busy, 0);
        check("reset_armed", armed, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        rst = 1'b0;
        tick(4);

        // Directed frames: normal transfers plus an underrun with nothing loaded.
        for (int v = 0; v < 5; v++) begin
            if (vecs[v].do_load) begin
                do_load(vecs[v].data);
                check($sformatf("vec%0d_armed", v), armed, 1);
                check($sformatf("vec%0d_miso_msb", v), miso, vecs[v].data[7]);
            end
            d0 = done_cnt;
            e0 = err_cnt;
            spi_frame(8, 1'b0, 8'h00, rx, busy_end);
            check($sformatf("vec%0d_rx", v), rx, vecs[v].exp_rx);
            check($sformatf("vec%0d_done", v), done_cnt - d0, vecs[v].exp_done);
            check($sformatf("vec%0d_err", v), err_cnt - e0, vecs[v].exp_err);
            check($sformatf("vec%0d_busy_in_frame", v), busy_end, 1);
            check($sformatf("vec%0d_busy_after", v), busy, 0);
        end

        // Abort after 4 bits, then a clean frame.
        do_load(8'h3C);
        d0 = done_cnt;
        e0 = err_cnt;
        spi_frame(4, 1'b0, 8'h00, rx, busy_end);
        check("abort_rx_nibble", rx, 8'h03);
        check("abort_err", err_cnt - e0, 1);
        check("abort_done", done_cnt - d0, 0);
        check("abort_idle", {armed, busy}, 2'b00);
        do_load(8'hC3);
        d0 = done_cnt;
        spi_frame(8, 1'b0, 8'h00, rx, busy_end);
        check("after_abort_rx", rx, 8'hC3);
        check("after_abort_done", done_cnt - d0, 1);

        // Overwrite while ARMED, and a load during SHIFT that must be ignored.
        do_load(8'h11);
        check("ovr_first_miso", miso, 0);
        do_load(8'h22);
        spi_frame(8, 1'b1, 8'hFF, rx, busy_end);
        check("ovr_rx", rx, 8'h22);
        check("shift_load_ignored", armed, 0);

        // Load coinciding with the detected ss fall in IDLE: underrun, data discarded.
        d0 = done_cnt;
        e0 = err_cnt;
        ss = 1'b0;
        tick(2);
        do_load(8'hE7);
        tick(2);
        check("coinc_busy", busy, 1);
        check("coinc_armed", armed, 0);
        rx = '0;
        for (int i = 0; i < 8; i++) begin
            rx  = {rx[6:0], miso};
            sck = 1'b1;
            tick(4);
            sck = 1'b0;
            tick(4);
        end
        ss = 1'b1;
        tick(6);
        check("coinc_rx", rx, 8'h00);
        check("coinc_err", err_cnt - e0, 1);
        check("coinc_done", done_cnt - d0, 0);
        check("coinc_not_armed", armed, 0);

        // Reset in the middle of a frame.
        do_load(8'hA5);
        ss = 1'b0;
        tick(4);
        for (int i = 0; i < 3; i++) begin
            sck = 1'b1;
            tick(4);
            sck = 1'b0;
            tick(4);
        end
        d0  = done_cnt;
        e0  = err_cnt;
        rst = 1'b1;
        tick(1);
        check("midrst_outputs", {miso, busy, armed, done, err}, 5'b00000);
        ss = 1'b1;
        tick(4);
        rst = 1'b0;
        tick(6);
        check("midrst_no_done", done_cnt - d0, 0);
        check("midrst_no_err", err_cnt - e0, 0);
        check("midrst_idle", {armed, busy}, 2'b00);

        // Randomized frames against a frame-level model: last pre-frame load is sent, otherwise underrun.
        model_armed = 1'b0;
        model_data  = '0;
        for (int f = 0; f < 24; f++) begin
            n_loads = $urandom_range(0, 2);
            for (int k = 0; k < n_loads; k++) begin
                d = 8'($urandom);
                do_load(d);
                model_data  = d;
                model_armed = 1'b1;
            end
            mid = 1'($urandom_range(0, 1));
            md  = 8'($urandom);
            d0  = done_cnt;
            e0  = err_cnt;
            spi_frame(8, mid, md, rx, busy_end);
            exp_rx = model_armed ? model_data : 8'h00;
            check($sformatf("rand%0d_rx", f), rx, exp_rx);
            check($sformatf("rand%0d_done", f), done_cnt - d0, model_armed ? 1 : 0);
            check($sformatf("rand%0d_err", f), err_cnt - e0, model_armed ? 0 : 1);
            model_armed = 1'b0;
        end

        check("done_err_exclusive", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_slave_tx.md
SPI_SLAVE_TX -- requirements
Module: spi_slave_tx

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning the number of bits per frame (legal range 2..16).
REQ-002 The module SHALL have port clk, input, 1 bit: system clock, with all logic on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-004 The module SHALL have port data_in, input, WIDTH bits: the frame to transmit.
REQ-005 The module SHALL have port load, input, 1 bit: when high for one clk cycle, it captures data_in.
REQ-006 The module SHALL have port sck, input, 1 bit: SPI clock from the master, asynchronous to clk.
REQ-007 The module SHALL have port ss, input, 1 bit: active-low slave select from the master, asynchronous to clk.
REQ-008 The module SHALL have port miso, output, 1 bit: serial data to the master, always driven and never tri-stated.
REQ-009 The module SHALL have port busy, output, 1 bit: high in states SHIFT and WAIT_SS.
REQ-010 The module SHALL have port armed, output, 1 bit: high in state ARMED.
REQ-011 The module SHALL have port done, output, 1 bit: one-cycle pulse on frame completion.
REQ-012 The module SHALL have port err, output, 1 bit: one-cycle pulse on underrun or abort.

Function
REQ-013 Protocol SHALL be SPI mode 0 (CPOL=0, CPHA=0), MSB first: the master samples on the sck rising edge and the slave changes miso after the sck falling edge.
REQ-014 sck and ss SHALL each pass through a 2-flop synchronizer, followed by one edge-detect register; legal sck frequency is at most clk/8.
REQ-015 The state machine SHALL have states IDLE, ARMED, SHIFT and WAIT_SS.
REQ-016 In IDLE or ARMED, load=1 SHALL write data_in to the shift register on that edge and enter ARMED; in ARMED this overwrites the previous data.
REQ-017 load SHALL be ignored in SHIFT and WAIT_SS.
REQ-018 miso SHALL equal the shift register MSB, registered, so the first bit is valid before ss falls.
REQ-019 In IDLE, WAIT_SS and reset, miso SHALL be 0.
REQ-020 A synchronized ss falling edge in ARMED SHALL enter SHIFT and clear the bit counter.
REQ-021 In SHIFT, each synchronized sck rising edge SHALL increment the bit counter.
REQ-022 In SHIFT, each synchronized sck falling edge SHALL shift the register left with 0 fill.
REQ-023 On the WIDTH-th sck rising edge, the module SHALL pulse done and enter WAIT_SS; the following falling edge is ignored.
REQ-024 In WAIT_SS, a synchronized ss rising edge SHALL return to IDLE.
REQ-025 A synchronized ss rising edge in SHIFT (abort) SHALL pulse err, discard remaining bits, enter IDLE and not assert done.
REQ-026 A synchronized ss falling edge in IDLE (underrun) SHALL pulse err and enter WAIT_SS, with miso held 0 for the whole frame.
REQ-027 If a load and an ss falling edge coincide in IDLE, the load SHALL take effect and the ss edge SHALL count as an underrun; the loaded data is discarded.
REQ-028 sck edges while ss is high SHALL be ignored.
REQ-029 done and err SHALL never be high in the same cycle.

Reset
REQ-030 rst=1 SHALL force, on the next clk edge, state IDLE, shift register 0, bit counter 0, and synchronizers to sck=0 and ss=1.
REQ-031 Reset values SHALL be miso=0, busy=0, armed=0, done=0, err=0.
REQ-032 Reset during SHIFT SHALL abandon the frame with no done or err pulse.
REQ-033 After reset, a frame already in progress (ss still low) SHALL be treated as an underrun only if a fresh ss falling edge is detected.

Configuration
REQ-034 With SPI_SLAVE_TX_DBG_EN defined, the module SHALL add output ports _dbg_cs [1:0] (IDLE=0, ARMED=1, SHIFT=2, WAIT_SS=3) and _dbg_idx [3:0] (bit counter).
REQ-035 Without SPI_SLAVE_TX_DBG_EN, those ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-036 Load 8'hA5, then the master clocks 8 bits at clk/8 -> master receives 8'hA5, done pulses once, busy falls on ss high.
REQ-037 Back-to-back frames 8'h55, 8'hFF, 8'h01 with ss deasserted between them -> each received exactly, with 3 done pulses.
REQ-038 ss falls with no load -> err pulses, master reads 8'h00, no done.
REQ-039 Load 8'h3C, then ss rises after 4 bits -> err pulses, state IDLE, and a subsequent load of 8'hC3 transfers correctly.
REQ-040 Load 8'h11, then load 8'h22 while ARMED -> master receives 8'h22; a load during SHIFT is ignored.
REQ-041 rst asserted mid-frame -> all outputs at reset values on the next cycle, with no done or err pulse.
